// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial adder sequencer
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Counter must be able to hold WIDTH-1 with headroom for any WIDTH >= 2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_shreg.sv
// rtl/serial_add_shreg.sv - right-shifting register with parallel load and serial in/out
module serial_add_shreg
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_par,
  output logic             o_ser_out
);

  logic [WIDTH-1:0] r_data;

  // Load has priority; a shift moves toward the LSB and inserts the serial bit at the MSB.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {i_ser_in, r_data[WIDTH-1:1]};
    end
  end

  assign o_par     = r_data;
  assign o_ser_out = r_data[0];

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - drives one WIDTH-bit add through a Moore serial adder; optional SERADD_CHECK_EN self-check
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ser_rst,
  output logic             o_ser_a,
  output logic             o_ser_b,
  input  logic             i_ser_y,
  input  logic             i_ser_cout,
  output logic             o_err
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_shift_ops;
  logic             w_sum_shift;
  logic             w_finish;
  logic             w_last_bit;
  logic             w_a_ser;
  logic             w_b_ser;
  logic [WIDTH-1:0] w_sum_par;
  logic [WIDTH-1:0] w_sum_final;
  logic             w_unused_sum_ser;
  logic [WIDTH-1:0] w_unused_a_par;
  logic [WIDTH-1:0] w_unused_b_par;
  logic             w_unused_bits;

  assign w_accept    = (r_state == IDLE) && i_start;
  assign w_shift_ops = (r_state == SHIFT);
  // The adder output is one cycle behind its inputs, so the first SHIFT cycle has nothing to collect.
  assign w_sum_shift = ((r_state == SHIFT) && (r_cnt != '0)) || (r_state == DRAIN);
  assign w_finish    = (r_state == DRAIN);
  assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));
  // The DRAIN bit lands in the MSB on the same edge the result is published.
  assign w_sum_final = {i_ser_y, w_sum_par[WIDTH-1:1]};
  assign w_unused_bits = w_unused_sum_ser ^ w_sum_par[0];

  serial_add_shreg #(.WIDTH(WIDTH)) u_shreg_a (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_accept),
    .i_load_data (i_op_a),
    .i_shift     (w_shift_ops),
    .i_ser_in    (1'b0),
    .o_par       (w_unused_a_par),
    .o_ser_out   (w_a_ser)
  );

  serial_add_shreg #(.WIDTH(WIDTH)) u_shreg_b (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_accept),
    .i_load_data (i_op_b),
    .i_shift     (w_shift_ops),
    .i_ser_in    (1'b0),
    .o_par       (w_unused_b_par),
    .o_ser_out   (w_b_ser)
  );

  serial_add_shreg #(.WIDTH(WIDTH)) u_shreg_sum (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (1'b0),
    .i_load_data ({WIDTH{1'b0}}),
    .i_shift     (w_sum_shift),
    .i_ser_in    (i_ser_y),
    .o_par       (w_sum_par),
    .o_ser_out   (w_unused_sum_ser)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode; SHIFT lasts until the bit counter has seen WIDTH-1.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = CLR;
      CLR:     w_next = SHIFT;
      SHIFT:   if (w_last_bit) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore outputs; serial operand bits are only driven while shifting.
  always_comb begin
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_ser_a   = 1'b0;
    o_ser_b   = 1'b0;
    o_ser_rst = i_reset;
    case (r_state)
      CLR: begin
        o_busy    = 1'b1;
        o_ser_rst = 1'b1;
      end
      SHIFT: begin
        o_busy  = 1'b1;
        o_ser_a = w_a_ser;
        o_ser_b = w_b_ser;
      end
      DRAIN:   o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  // Bit counter: cleared in CLR, advances once per SHIFT cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state == CLR)) r_cnt <= '0;
    else if (r_state == SHIFT)       r_cnt <= r_cnt + CW'(1);
  end

  // Result registers hold the previous answer until the next operation completes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_finish) begin
      r_sum  <= w_sum_final;
      r_cout <= i_ser_cout;
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;

`ifdef SERADD_CHECK_EN
  logic [WIDTH:0] r_ref;
  logic           r_err;

  // Parallel reference captured with the operands; sticky mismatch flag set when the result publishes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ref <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_ref <= {1'b0, i_op_a} + {1'b0, i_op_b};
      r_err <= 1'b0;
    end else if (w_finish && (r_ref != {i_ser_cout, w_sum_final})) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - randomized self-checking bench with a Moore serial adder model
module tb_serial_add_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, cout, ser_rst, ser_a, ser_b, ser_y, ser_cout, err;
  logic [W-1:0] sum;

  logic         m_y = 1'b0;
  logic         m_c = 1'b0;
  logic         flip = 1'b0;

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_err = 1'b0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_ser_rst  (ser_rst),
    .o_ser_a    (ser_a),
    .o_ser_b    (ser_b),
    .i_ser_y    (ser_y),
    .i_ser_cout (ser_cout),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Moore serial adder: registered sum bit and carry, cleared by ser_rst.
  always @(posedge clk) begin
    if (ser_rst) begin
      m_y <= 1'b0;
      m_c <= 1'b0;
    end else begin
      {m_c, m_y} <= {1'b0, ser_a} + {1'b0, ser_b} + {1'b0, m_c};
    end
  end

  assign ser_y    = m_y ^ flip;
  assign ser_cout = m_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit spam, input bit glitch);
    logic [W:0] ref_v;
    logic       want_err;
    ref_v = {1'b0, a} + {1'b0, b};
    if (glitch) ref_v[0] = ~ref_v[0];
`ifdef SERADD_CHECK_EN
    want_err = glitch;
`else
    want_err = 1'b0;
`endif
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_err_hold", err, last_err);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("clr_ser_rst", ser_rst, 1);
        chk("clr_err_cleared", err, 0);
      end
      if (k >= 2 && k <= W + 1) begin
        chk("shift_ser_a", ser_a, a[k-2]);
        chk("shift_ser_b", ser_b, b[k-2]);
        chk("shift_ser_rst", ser_rst, 0);
      end else begin
        chk("ser_a_zero", ser_a, 0);
        chk("ser_b_zero", ser_b, 0);
      end
      if (k <= W + 2) begin
        chk("busy", busy, 1);
        chk("no_done", done, 0);
        chk("sum_hold", sum, last_sum);
        chk("cout_hold", cout, last_cout);
      end else begin
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("sum", sum, ref_v[W-1:0]);
        chk("cout", cout, ref_v[W]);
        chk("err", err, want_err);
      end
      start = spam;
      if (spam) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
      end
      flip = glitch && (k == 3);
    end
    flip      = 1'b0;
    last_sum  = ref_v[W-1:0];
    last_cout = ref_v[W];
    last_err  = want_err;
    @(negedge clk);
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_err_sticky", err, want_err);
    if (spam) begin
      repeat (2) begin
        @(negedge clk);
        chk("spam_no_done", done, 0);
        chk("spam_no_busy", busy, 0);
        chk("spam_sum_hold", sum, last_sum);
      end
    end
  endtask

  task automatic reset_mid(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_ser_rst", ser_rst, 1);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err", err, 0);
    chk("rst_ser_a", ser_a, 0);
    chk("rst_ser_rst_hold", ser_rst, 1);
    reset     = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    last_err  = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_no_busy", busy, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_err", err, 0);
    chk("reset_ser_a", ser_a, 0);
    chk("reset_ser_b", ser_b, 0);
    chk("reset_ser_rst", ser_rst, 1);
    reset = 1'b0;

    run_op(4'd5, 4'd3, 1'b0, 1'b0);
    run_op(4'hF, 4'h1, 1'b0, 1'b0);
    run_op(4'hF, 4'hF, 1'b0, 1'b0);
    run_op(4'h0, 4'h0, 1'b0, 1'b0);
    run_op(4'd9, 4'd6, 1'b1, 1'b0);
    reset_mid(4'hA, 4'hB);
    run_op(4'd6, 4'd7, 1'b0, 1'b0);
    run_op(4'd3, 4'd4, 1'b0, 1'b1);
    run_op(4'd2, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Controller that runs one WIDTH-bit addition on the team's Moore-style serial adder.
- Latches parallel operands and feeds them LSB-first onto the adder's bit-serial inputs.
- Re-parallelises the registered sum-bit stream and the final carry.
- Sits between a parallel requester (start/done handshake) and the serial adder.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op_a  input  WIDTH  operand A; latched on accepted start
op_b  input  WIDTH  operand B; latched on accepted start
busy  output  1  high in CLR, SHIFT and DRAIN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result register
cout  output  1  final carry
ser_rst  output  1  clear to the serial adder; = reset OR (state==CLR)
ser_a  output  1  serial bit of A
ser_b  output  1  serial bit of B
ser_y  input  1  adder's registered sum bit; Moore, 1-cycle latency
ser_cout  input  1  adder's registered carry state
err  output  1  self-check flag; see Optional Feature

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0, err=0, ser_a=0, ser_b=0; ser_rst=1 while reset is high.
- Reset mid-operation: aborts the operation, returns to IDLE and drives the reset values. No done pulse is issued for the aborted operation.
- Start accepted: start=1 in IDLE at edge E.
  - Latch op_a/op_b into shift registers.
  - Go to CLR.
- CLR, 1 cycle: ser_rst=1, ser_a=ser_b=0. Clear bit counter. Go to SHIFT.
- SHIFT, exactly WIDTH cycles:
  - ser_a/ser_b = LSB of the operand shift registers; shift right each edge.
  - From the 2nd SHIFT cycle onward, capture ser_y at the cycle end into a sum shift register, MSB-insert. The bit captured in cycle j is sum bit j-1.
  - After the counter reaches WIDTH-1, go to DRAIN.
- DRAIN, 1 cycle:
  - ser_a=ser_b=0.
  - Capture ser_y as sum bit WIDTH-1 and ser_cout as the carry.
  - Copy the assembled value into the sum/cout output registers at the DRAIN->DONE edge.
- DONE, 1 cycle: done=1, busy=0. Go to IDLE.
- Latency: done is high in the cycle after edge E+WIDTH+2, i.e. WIDTH+3 cycles after the accepting edge.
- Result semantics: {cout,sum} = op_a + op_b, modulo 2^(WIDTH+1); no overflow flag.
- sum/cout hold the last result until the next DONE. They are not cleared by start.
- start outside IDLE, including during DONE, is ignored with no queuing. Back-to-back operation: start in the first IDLE cycle after DONE is accepted.
- ser_a/ser_b are 0 in every state except SHIFT.

Optional Feature:
SERADD_CHECK_EN
- Defined:
  - On accepted start, latch the parallel reference op_a+op_b (WIDTH+1 bits).
  - At the DRAIN->DONE edge, compare it with {cout,sum} and set err=1 on mismatch.
  - err is sticky; cleared by reset or by the next accepted start.
- Undefined: the reference register is not built and err is tied to 0.

Decomposition:
- Package serial_add_pkg:
  - state encoding typedef {IDLE, CLR, SHIFT, DRAIN, DONE}.
  - default WIDTH constant.
  - counter width function, $clog2(WIDTH)+1.
- Sub-module serial_add_shreg: parameterised WIDTH shift register with parallel load, shift enable and serial in/out.
  - Instanced three times: A, B and sum collection.
  - FSM and counter stay in the top.

Test Plan:
Bench pairs the sequencer with the existing Moore serial adder model; WIDTH=4.
- op_a=5, op_b=3, start pulse -> busy for 6 cycles, done exactly 7 cycles after the accepting edge, sum=8, cout=0, err=0.
- op_a=4'hF, op_b=4'h1 -> sum=0, cout=1; also 4'hF+4'hF -> sum=4'hE, cout=1.
- 0+0 after a nonzero result -> sum holds the prior value until done, then sum=0, cout=0.
- start re-asserted with different operands while busy and during the DONE cycle -> ignored; the first result is correct and no second done appears.
- reset raised during the 2nd SHIFT cycle -> next cycle IDLE, busy=0, no done pulse, ser_rst=1 during reset; a following 6+7 operation gives sum=13, cout=0.
- SERADD_CHECK_EN defined, with the bench model forcing ser_y inverted for one bit -> err=1 after done, cleared on the next accepted start.
